divmod_seq: RTL and testbench
=============================

Name:
divmod_seq

Overview:
- Parametrised sequential divider and modulo unit; successor to the single-width repeated-subtraction mod datapath.
- Computes quotient and remainder together using restoring shift-subtract, one quotient bit per cycle, so latency is fixed rather than data-dependent.
- Adds optional signed operation, divide-by-zero detection and a start/busy/done handshake.
- Sits beside the ALU as the multi-cycle DIV/DIVU/MOD unit; the ALU control unit issues start and waits for done.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 4).
- SIGNED_EN, 1, 1 = honour signed_op; 0 = signed_op ignored and all operations are unsigned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when state is IDLE.
- signed_op  input  1  1 = two's-complement operands; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when quotient and remainder become valid.
- quotient  output  WIDTH  registered result; held until the next done.
- remainder  output  WIDTH  registered result; held until the next done.
- div_by_zero  output  1  registered flag, updated with every done.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0; internal counter and working registers = 0. Reset asserted mid-operation aborts it and no done is produced.
- States:
  - IDLE → CALC: start = 1 and divisor ≠ 0.
  - IDLE → IDLE (zero-divide path): start = 1 and divisor = 0.
  - CALC → FIX: after exactly WIDTH iterations.
  - FIX → IDLE: always.
- Start edge (E0), IDLE with start = 1 and divisor ≠ 0:
  - Latch the sign flags: neg_q = sa XOR sb; neg_r = sa. Here sa and sb are the operand MSBs when signed_op = 1 and SIGNED_EN = 1, otherwise 0.
  - Load the magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values.
  - Clear the partial remainder (WIDTH + 1 bits). Set the counter to WIDTH.
  - Set busy = 1.
- CALC, one iteration per edge:
  - Shift {partial remainder, dividend shift register} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. The iteration at edge E_WIDTH moves the state to FIX.
- FIX, edge E(WIDTH+1):
  - quotient ← neg_q ? −q : q; remainder ← neg_r ? −r : r.
  - div_by_zero ← 0; done ← 1; busy ← 0; state ← IDLE.
- Latency: done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH + 2 cycles counting the start cycle. Busy is high for cycles E0+1 through E(WIDTH+1).
- Divide by zero (start in IDLE with divisor = 0):
  - At E0: quotient ← all ones; remainder ← dividend unchanged; div_by_zero ← 1; done ← 1.
  - busy stays 0 and the state stays IDLE (latency 1).
- Signed overflow (SIGNED_EN = 1, signed_op = 1, dividend = most negative value, divisor = −1): quotient = most negative value, remainder = 0, div_by_zero = 0, normal latency. This falls out of the magnitude arithmetic modulo 2^WIDTH; no special case is required.
- Sign rules: quotient truncates toward zero; a nonzero remainder takes the sign of the dividend; |remainder| < |divisor|.
- Handshake:
  - start while busy is ignored, and operand changes during CALC have no effect.
  - done lasts exactly one cycle. The state is IDLE during the done cycle, so a start in that same cycle is accepted (back-to-back, no bubble).
  - quotient, remainder and div_by_zero change only on the edge that raises done, or on reset.

Test Plan:
- WIDTH = 32, unsigned, 100 / 7 → quotient 14, remainder 2, div_by_zero 0; done exactly 34 cycles after the start cycle; busy high for 33 cycles.
- signed_op = 1: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). 7 / −2 → −3, 1. −8 / −2 → 4, 0. Same bit patterns with signed_op = 0 → 0xFFFFFFF9 / 2 = 0x7FFFFFFC, remainder 1.
- Divisor 0, dividend 5 → quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, done the cycle after start, busy never rises. The next valid operation clears div_by_zero.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → 0xFFFFFFFF, 0. 3 / 10 → 0, 3.
- start pulsed with different operands mid-CALC → ignored, first result intact. start asserted in the done cycle → second result follows 34 cycles later.
- Reset asserted asynchronously at cycle 10 of CALC → all outputs 0 immediately, no done pulse. A fresh 100 / 7 afterwards completes normally. Repeat with WIDTH = 8, SIGNED_EN = 0: signed_op ignored, latency 10 cycles.

Source files
------------

// File: rtl/divmod_seq.sv
// divmod_seq: multi-cycle restoring divider producing quotient and remainder.
// One quotient bit per cycle, fixed latency of WIDTH + 2 cycles from start.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 4)
//   SIGNED_EN  1 = honour signed_op, 0 = always unsigned
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        request, only accepted while idle
//   signed_op    two's-complement operation, sampled with start
//   dividend     sampled with start
//   divisor      sampled with start
//   busy         operation in flight
//   done         one-cycle pulse when results update
//   quotient     registered result, held until the next done
//   remainder    registered result, held until the next done
//   div_by_zero  registered flag, updated with every done
module divmod_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] prem, prem_nx;     // partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] dq, dq_nx;         // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvs, dvs_nx;       // divisor magnitude
    logic [CW-1:0]    cnt, cnt_nx;
    logic             neg_q, neg_q_nx;
    logic             neg_r, neg_r_nx;
    logic             busy_nx, done_nx, dbz_nx;
    logic [WIDTH-1:0] quotient_nx, remainder_nx;

    logic             sa, sb;
    logic [WIDTH:0]   shifted, trial;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prem        <= '0;
            dq          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nx;
            prem        <= prem_nx;
            dq          <= dq_nx;
            dvs         <= dvs_nx;
            cnt         <= cnt_nx;
            neg_q       <= neg_q_nx;
            neg_r       <= neg_r_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            quotient    <= quotient_nx;
            remainder   <= remainder_nx;
            div_by_zero <= dbz_nx;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_nx     = state;
        prem_nx      = prem;
        dq_nx        = dq;
        dvs_nx       = dvs;
        cnt_nx       = cnt;
        neg_q_nx     = neg_q;
        neg_r_nx     = neg_r;
        busy_nx      = busy;
        done_nx      = 1'b0;
        quotient_nx  = quotient;
        remainder_nx = remainder;
        dbz_nx       = div_by_zero;

        sa      = SIGNED_EN && signed_op && dividend[WIDTH-1];
        sb      = SIGNED_EN && signed_op && divisor[WIDTH-1];
        // One restoring step: bring in the next dividend bit, try to subtract
        shifted = {prem, dq[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_nx  = {WIDTH{1'b1}};
                        remainder_nx = dividend;
                        dbz_nx       = 1'b1;
                        done_nx      = 1'b1;
                    end else begin
                        neg_q_nx = sa ^ sb;
                        neg_r_nx = sa;
                        // most-negative operand negates to itself, which is its
                        // correct unsigned magnitude
                        dq_nx    = sa ? -dividend : dividend;
                        dvs_nx   = sb ? -divisor : divisor;
                        prem_nx  = '0;
                        cnt_nx   = CW'(WIDTH);
                        busy_nx  = 1'b1;
                        state_nx = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    prem_nx = trial[WIDTH-1:0];
                    dq_nx   = {dq[WIDTH-2:0], 1'b1};
                end else begin
                    prem_nx = shifted[WIDTH-1:0];
                    dq_nx   = {dq[WIDTH-2:0], 1'b0};
                end
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                quotient_nx  = neg_q ? -dq : dq;
                remainder_nx = neg_r ? -prem : prem;
                dbz_nx       = 1'b0;
                done_nx      = 1'b1;
                busy_nx      = 1'b0;
                state_nx     = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_divmod_seq.sv
// tb_divmod_seq: table-driven bench with scoreboard queues for a 32-bit signed
// instance and an 8-bit unsigned-only instance of divmod_seq.
module tb_divmod_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    typedef struct {
        bit          so;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
        int          bsy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst32, rst8;
    logic        start32, so32, start8, so8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [31:0] quo32, rem32;
    logic [7:0]  quo8, rem8;

    int   checks = 0;
    int   errors = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;

    always #5 clk = ~clk;

    divmod_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .reset(rst32), .start(start32), .signed_op(so32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(quo32), .remainder(rem32), .div_by_zero(dbz32)
    );

    divmod_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .signed_op(so8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    // Scoreboard pops on every done pulse
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_unexpected got=1 exp=0 at %0t", $time);
            end else begin
                m32 = q32.pop_front();
                chk("quotient32", quo32, m32.q);
                chk("remainder32", rem32, m32.r);
                chk("dbz32", 32'(dbz32), 32'(m32.dz));
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected got=1 exp=0 at %0t", $time);
            end else begin
                m8 = q8.pop_front();
                chk("quotient8", {24'b0, quo8}, m8.q);
                chk("remainder8", {24'b0, rem8}, m8.r);
                chk("dbz8", 32'(dbz8), 32'(m8.dz));
            end
        end
    end

    // Drive a request (called at a negedge) and queue its expected result
    task automatic launch(input bit w8, input bit so, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input bit edz);
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = edz;
        if (w8) begin
            start8 = 1'b1; so8 = so; a8 = a[7:0]; b8 = b[7:0];
            q8.push_back(e);
        end else begin
            start32 = 1'b1; so32 = so; a32 = a; b32 = b;
            q32.push_back(e);
        end
    endtask

    task automatic drop_start(input bit w8);
        if (w8) start8 = 1'b0;
        else    start32 = 1'b0;
    endtask

    // Wait for done, checking latency and busy cycles; optionally pulse a
    // conflicting start (zero divisor) partway through the calculation
    task automatic wait_done(input bit w8, input int exp_lat, input int exp_busy, input int glitch_at);
        int lat  = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) drop_start(w8);
            if (glitch_at != 0 && lat == glitch_at) begin
                if (w8) begin start8 = 1'b1; a8 = 8'h5A; b8 = 8'h00; end
                else begin start32 = 1'b1; a32 = 32'h1234; b32 = 32'h0; end
            end
            if (glitch_at != 0 && lat == glitch_at + 1) drop_start(w8);
            if (get_busy(w8)) bcnt++;
            if (get_done(w8)) seen = 1'b1;
        end
        chk(w8 ? "done8_seen" : "done32_seen", 32'(seen), 32'd1);
        chk(w8 ? "latency8" : "latency32", 32'(lat), 32'(exp_lat));
        chk(w8 ? "busy_cycles8" : "busy_cycles32", 32'(bcnt), 32'(exp_busy));
    endtask

    // Abort an operation with an asynchronous reset mid-calculation
    task automatic abort_run(input bit w8, input int at);
        launch(w8, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        for (int i = 0; i < at; i++) begin
            @(negedge clk);
            if (i == 0) drop_start(w8);
        end
        chk(w8 ? "busy8_before_abort" : "busy32_before_abort", 32'(get_busy(w8)), 32'd1);
        #2;
        if (w8) rst8 = 1'b1;
        else    rst32 = 1'b1;
        #1;
        if (w8) begin
            chk("abort8_busy_done_dbz", {29'b0, busy8, done8, dbz8}, 32'd0);
            chk("abort8_quotient", {24'b0, quo8}, 32'd0);
            chk("abort8_remainder", {24'b0, rem8}, 32'd0);
            q8.delete();
        end else begin
            chk("abort32_busy_done_dbz", {29'b0, busy32, done32, dbz32}, 32'd0);
            chk("abort32_quotient", quo32, 32'd0);
            chk("abort32_remainder", rem32, 32'd0);
            q32.delete();
        end
        @(negedge clk);
        if (w8) rst8 = 1'b0;
        else    rst32 = 1'b0;
        repeat (40) @(negedge clk);
        launch(w8, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_done(w8, w8 ? 10 : 34, w8 ? 9 : 33, 0);
    endtask

    vec_t tab32[12];
    vec_t tab8[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, rq, rr;
        bit          rs;

        tab32[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33};
        tab32[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 33};
        tab32[2]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 34, 33};
        tab32[3]  = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd4, 32'd0, 1'b0, 34, 33};
        tab32[4]  = '{1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 34, 33};
        tab32[5]  = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 0};
        tab32[6]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33};
        tab32[7]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34, 33};
        tab32[8]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34, 33};
        tab32[9]  = '{1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1, 0};
        tab32[10] = '{1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 33};
        tab32[11] = '{1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34, 33};

        tab8[0] = '{1'b1, 32'hF9, 32'd2, 32'h7C, 32'd1, 1'b0, 10, 9};
        tab8[1] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, 9};
        tab8[2] = '{1'b0, 32'hFF, 32'd1, 32'hFF, 32'd0, 1'b0, 10, 9};
        tab8[3] = '{1'b0, 32'd0, 32'd0, 32'hFF, 32'd0, 1'b1, 1, 0};
        tab8[4] = '{1'b1, 32'd200, 32'd13, 32'd15, 32'd5, 1'b0, 10, 9};
        tab8[5] = '{1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 10, 9};

        rst32 = 1'b1; rst8 = 1'b1;
        start32 = 1'b0; so32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; so8 = 1'b0; a8 = '0; b8 = '0;
        #1;
        chk("reset32_flags", {29'b0, busy32, done32, dbz32}, 32'd0);
        chk("reset32_results", quo32 | rem32, 32'd0);
        chk("reset8_flags", {29'b0, busy8, done8, dbz8}, 32'd0);
        chk("reset8_results", {24'b0, quo8 | rem8}, 32'd0);
        @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;
        @(negedge clk);

        foreach (tab32[i]) begin
            launch(1'b0, tab32[i].so, tab32[i].a, tab32[i].b, tab32[i].q, tab32[i].r, tab32[i].dz);
            wait_done(1'b0, tab32[i].lat, tab32[i].bsy, 0);
        end
        foreach (tab8[i]) begin
            launch(1'b1, tab8[i].so, tab8[i].a, tab8[i].b, tab8[i].q, tab8[i].r, tab8[i].dz);
            wait_done(1'b1, tab8[i].lat, tab8[i].bsy, 0);
        end

        // Random operands against the language's own division operators
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 30);
            if (rb == 32'd0) rb = 32'd3;
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
            if (rs) begin
                rq = 32'($signed(ra) / $signed(rb));
                rr = 32'($signed(ra) % $signed(rb));
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            launch(1'b0, rs, ra, rb, rq, rr, 1'b0);
            wait_done(1'b0, 34, 33, 0);
        end

        // Start pulsed mid-calculation with other operands is ignored
        launch(1'b0, 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
        wait_done(1'b0, 34, 33, 5);
        launch(1'b1, 1'b0, 32'd200, 32'd13, 32'd15, 32'd5, 1'b0);
        wait_done(1'b1, 10, 9, 3);

        // Start in the done cycle is accepted with no bubble
        launch(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_done(1'b0, 34, 33, 0);
        launch(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        wait_done(1'b0, 34, 33, 0);
        launch(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_done(1'b1, 10, 9, 0);
        launch(1'b1, 1'b0, 32'd250, 32'd16, 32'd15, 32'd10, 1'b0);
        wait_done(1'b1, 10, 9, 0);

        abort_run(1'b0, 10);
        abort_run(1'b1, 4);

        repeat (3) @(negedge clk);
        chk("scoreboard32_drained", 32'(q32.size()), 32'd0);
        chk("scoreboard8_drained", 32'(q8.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
